multicycle_control_unit: RTL and testbench
==========================================

Name: multicycle_control_unit

Overview:
- Main control FSM for the multicycle CPU datapath; sits directly upstream of the datapath and drives every datapath control line (PCWre, IRWre, InsMemRW, ExtSel, RegOut, RegWre, ALUSrcA, ALUSrcB, ALUM2Reg, WrRegData, PCSrc, ALUOp, DataMemRW).
- Consumes the IR opcode and the ALU zero flag; sequences IF→ID→EXE→MEM→WB per instruction class.
- Also keeps a retired-instruction counter for bench and debug use.

Parameters:
- CNT_W, 32, width of instr_count.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- opcode  in  6  IR[31:26]; valid from ID until the next IF.
- zero  in  1  ALU zero flag; sampled in EXE_BR.
- PCWre  out  1  PC write enable.
- IRWre  out  1  IR load enable.
- InsMemRW  out  1  instruction memory read enable.
- ExtSel  out  2  00 zero-ext shamt, 01 zero-ext imm16, 10 sign-ext imm16.
- RegOut  out  2  write register select: 00 $31, 01 rt, 10 rd.
- RegWre  out  1  register file write enable.
- ALUSrcA  out  1  ALU A source: 0 rs, 1 shamt.
- ALUSrcB  out  1  ALU B source: 0 rt, 1 extended immediate.
- ALUM2Reg  out  1  writeback source: 0 ALU result, 1 memory data.
- WrRegData  out  1  register write data: 0 PC+4 (jal), 1 ALU/memory path.
- PCSrc  out  2  next PC: 00 PC+4, 01 branch target, 10 rs (jr), 11 jump target.
- ALUOp  out  3  000 ADD, 001 SUB, 010 SLTU, 011 SLT, 100 SLL, 101 OR, 110 AND, 111 XOR.
- DataMemRW  out  1  data memory access: 0 read, 1 write.
- state  out  4  current FSM state.
- instr_count  out  CNT_W  retired-instruction count.
- illegal_op  out  1  sticky illegal-opcode flag.

Behaviour:
- Opcodes:
  - 000000 add, 000001 sub, 000010 addi.
  - 010000 or, 010001 and, 010010 ori.
  - 011000 sll, 100110 slt, 100111 sltiu.
  - 110000 sw, 110001 lw, 110100 beq.
  - 111000 j, 111001 jr, 111010 jal, 111111 halt.
- States: IF, ID, EXE_AL, EXE_BR, EXE_LS, MEM, WB_AL, WB_LD, HALT.
- Transitions:
  - IF → ID.
  - ID → IF for j/jr/jal; → HALT for halt; → EXE_BR for beq; → EXE_LS for lw/sw; otherwise → EXE_AL.
  - EXE_AL → WB_AL → IF.
  - EXE_BR → IF.
  - EXE_LS → MEM.
  - MEM → IF for sw; → WB_LD for lw.
  - WB_LD → IF.
  - HALT holds until rst.
- Cycle counts:
  - R-type and immediate ALU instructions: 4.
  - beq: 3.
  - sw: 4.
  - lw: 5.
  - j/jr/jal: 2.
- Outputs are a combinational decode of the registered state, opcode and zero; all enables are 0 in every state unless stated below.
  - IF: InsMemRW=1, IRWre=1.
  - PCWre=1 only in the final cycle of each instruction: ID for jumps, EXE_BR, MEM for sw, WB_AL, WB_LD.
  - PCSrc:
    - 11 for j/jal.
    - 10 for jr.
    - In EXE_BR: 01 if zero=1, 00 if zero=0.
    - 00 everywhere else.
  - jal in ID: RegWre=1, RegOut=00, WrRegData=0.
  - WB_AL: RegWre=1, WrRegData=1, ALUM2Reg=0; RegOut=10 for R-type, 01 for immediates.
  - WB_LD: RegWre=1, RegOut=01, ALUM2Reg=1, WrRegData=1.
  - MEM: DataMemRW=1 for sw, 0 for lw.
  - ALUSrcB=1 for addi/ori/sltiu/lw/sw.
  - ALUSrcA=1 for sll.
  - ExtSel: 10 for addi/lw/sw/beq/sltiu; 01 for ori; 00 for sll.
  - ALUOp: add/addi/lw/sw → ADD; sub/beq → SUB; sltiu → SLTU; slt → SLT; sll → SLL; or/ori → OR; and → AND.
  - ALUOp and the mux selects are held stable from ID through the last cycle of the instruction.
- instr_count increments by 1 on every clock edge where PCWre=1; it wraps modulo 2^CNT_W.
- Reset:
  - While rst=1: state=IF, instr_count=0, illegal_op=0, and all enables (PCWre, IRWre, InsMemRW, RegWre, DataMemRW) are forced to 0 regardless of state.
  - Reset mid-instruction aborts it with no further writes.
  - The first IF cycle begins on the first rising edge after rst deasserts.
- HALT: all enables 0; instr_count frozen.

Optional Feature:
- Macro: ILLEGAL_OP_TRAP_EN.
- Defined: an unlisted opcode in ID → HALT with illegal_op=1 (sticky until rst); the instruction is not counted.
- Undefined: an unlisted opcode is a 2-cycle NOP (ID → IF, PCWre=1, PCSrc=00, counted); illegal_op is tied to 0.

Decomposition:
- Package mc_ctrl_pkg: state encodings, opcode constants, ALUOp/PCSrc/ExtSel/RegOut codes.
- Sub-module mc_ctrl_decode: combinational opcode → class (R, I-ALU, LS, BR, JMP, HALT, ILLEGAL) plus static selects (ALUOp, ExtSel, ALUSrcA/B, RegOut).
- The FSM, output gating and counter stay in the top.

Test Plan:
- rst pulsed high for 3 cycles, then released with opcode=000000 → state IF, IF, ID, EXE_AL, WB_AL; PCWre=1 only in WB_AL; RegOut=10; instr_count=1.
- beq with zero=1 → 3 cycles, PCSrc=01 in EXE_BR with PCWre=1; repeat with zero=0 → PCSrc=00.
- lw then sw → lw takes 5 cycles with DataMemRW=0 in MEM and RegWre=1, ALUM2Reg=1 in WB_LD; sw takes 4 cycles with DataMemRW=1 in MEM and RegWre never asserted; instr_count=2.
- jal → ID asserts RegWre=1, RegOut=00, WrRegData=0, PCSrc=11, PCWre=1; next state IF.
- rst asserted asynchronously mid-EXE_LS of lw → outputs drop immediately; no DataMemRW or RegWre pulse; state=IF; instr_count=0.
- halt → state HALT persists for 20 cycles with all enables 0. Opcode 101010 with ILLEGAL_OP_TRAP_EN defined → HALT with illegal_op=1; with the macro undefined → NOP with instr_count +1.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle CPU control unit: FSM states, opcodes,
// instruction classes and the datapath select codes.
package mc_ctrl_pkg;

  // Values are visible on the 'state' port.
  typedef enum logic [3:0] {
    S_IF     = 4'd0,
    S_ID     = 4'd1,
    S_EXE_AL = 4'd2,
    S_EXE_BR = 4'd3,
    S_EXE_LS = 4'd4,
    S_MEM    = 4'd5,
    S_WB_AL  = 4'd6,
    S_WB_LD  = 4'd7,
    S_HALT   = 4'd8
  } state_e;

  typedef enum logic [2:0] {
    C_R,
    C_IALU,
    C_LS,
    C_BR,
    C_JMP,
    C_HALT,
    C_ILLEGAL
  } instr_class_e;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_ADDI  = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b010000;
  localparam logic [5:0] OP_AND   = 6'b010001;
  localparam logic [5:0] OP_ORI   = 6'b010010;
  localparam logic [5:0] OP_SLL   = 6'b011000;
  localparam logic [5:0] OP_SLT   = 6'b100110;
  localparam logic [5:0] OP_SLTIU = 6'b100111;
  localparam logic [5:0] OP_SW    = 6'b110000;
  localparam logic [5:0] OP_LW    = 6'b110001;
  localparam logic [5:0] OP_BEQ   = 6'b110100;
  localparam logic [5:0] OP_J     = 6'b111000;
  localparam logic [5:0] OP_JR    = 6'b111001;
  localparam logic [5:0] OP_JAL   = 6'b111010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_SLTU = 3'b010;
  localparam logic [2:0] ALU_SLT  = 3'b011;
  localparam logic [2:0] ALU_SLL  = 3'b100;
  localparam logic [2:0] ALU_OR   = 3'b101;
  localparam logic [2:0] ALU_AND  = 3'b110;

  localparam logic [1:0] PC_NEXT   = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_RS     = 2'b10;
  localparam logic [1:0] PC_JUMP   = 2'b11;

  localparam logic [1:0] EXT_SHAMT = 2'b00;
  localparam logic [1:0] EXT_ZERO  = 2'b01;
  localparam logic [1:0] EXT_SIGN  = 2'b10;

  localparam logic [1:0] RO_RA = 2'b00;
  localparam logic [1:0] RO_RT = 2'b01;
  localparam logic [1:0] RO_RD = 2'b10;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational opcode decode: instruction class plus the static datapath
// selects that stay constant for the whole instruction.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0]   opcode_i,
  output instr_class_e cls_o,
  output logic [2:0]   alu_op_o,
  output logic [1:0]   ext_sel_o,
  output logic         alu_src_a_o,
  output logic         alu_src_b_o,
  output logic [1:0]   reg_out_o
);

  always_comb begin
    cls_o       = C_ILLEGAL;
    alu_op_o    = ALU_ADD;
    ext_sel_o   = EXT_SHAMT;
    alu_src_a_o = 1'b0;
    alu_src_b_o = 1'b0;
    reg_out_o   = RO_RA;
    case (opcode_i)
      OP_ADD:   begin cls_o = C_R; reg_out_o = RO_RD; end
      OP_SUB:   begin cls_o = C_R; alu_op_o = ALU_SUB; reg_out_o = RO_RD; end
      OP_OR:    begin cls_o = C_R; alu_op_o = ALU_OR;  reg_out_o = RO_RD; end
      OP_AND:   begin cls_o = C_R; alu_op_o = ALU_AND; reg_out_o = RO_RD; end
      OP_SLT:   begin cls_o = C_R; alu_op_o = ALU_SLT; reg_out_o = RO_RD; end
      OP_SLL: begin
        cls_o       = C_R;
        alu_op_o    = ALU_SLL;
        ext_sel_o   = EXT_SHAMT;
        alu_src_a_o = 1'b1;
        reg_out_o   = RO_RD;
      end
      OP_ADDI: begin
        cls_o = C_IALU; ext_sel_o = EXT_SIGN; alu_src_b_o = 1'b1; reg_out_o = RO_RT;
      end
      OP_ORI: begin
        cls_o = C_IALU; alu_op_o = ALU_OR; ext_sel_o = EXT_ZERO;
        alu_src_b_o = 1'b1; reg_out_o = RO_RT;
      end
      OP_SLTIU: begin
        cls_o = C_IALU; alu_op_o = ALU_SLTU; ext_sel_o = EXT_SIGN;
        alu_src_b_o = 1'b1; reg_out_o = RO_RT;
      end
      OP_SW, OP_LW: begin
        cls_o = C_LS; ext_sel_o = EXT_SIGN; alu_src_b_o = 1'b1; reg_out_o = RO_RT;
      end
      OP_BEQ:            begin cls_o = C_BR; alu_op_o = ALU_SUB; ext_sel_o = EXT_SIGN; end
      OP_J, OP_JR, OP_JAL: cls_o = C_JMP;
      OP_HALT:             cls_o = C_HALT;
      default:             cls_o = C_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle CPU control FSM with retired-instruction counter.
// Define ILLEGAL_OP_TRAP_EN to trap unlisted opcodes into HALT (sticky illegal_op).
module multicycle_control_unit
  import mc_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             zero,
  output logic             PCWre,
  output logic             IRWre,
  output logic             InsMemRW,
  output logic [1:0]       ExtSel,
  output logic [1:0]       RegOut,
  output logic             RegWre,
  output logic             ALUSrcA,
  output logic             ALUSrcB,
  output logic             ALUM2Reg,
  output logic             WrRegData,
  output logic [1:0]       PCSrc,
  output logic [2:0]       ALUOp,
  output logic             DataMemRW,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_count,
  output logic             illegal_op
);

  state_e           state_q;
  logic [CNT_W-1:0] count_q;
  instr_class_e     cls;
  logic             is_jal, is_jr, is_lw, is_sw;

  mc_ctrl_decode u_decode (
    .opcode_i    (opcode),
    .cls_o       (cls),
    .alu_op_o    (ALUOp),
    .ext_sel_o   (ExtSel),
    .alu_src_a_o (ALUSrcA),
    .alu_src_b_o (ALUSrcB),
    .reg_out_o   (RegOut)
  );

  assign is_jal = (opcode == OP_JAL);
  assign is_jr  = (opcode == OP_JR);
  assign is_lw  = (opcode == OP_LW);
  assign is_sw  = (opcode == OP_SW);

  assign state       = state_q;
  assign instr_count = count_q;

  always_comb begin
    PCWre     = 1'b0;
    IRWre     = 1'b0;
    InsMemRW  = 1'b0;
    RegWre    = 1'b0;
    DataMemRW = 1'b0;
    ALUM2Reg  = 1'b0;
    WrRegData = 1'b0;
    PCSrc     = PC_NEXT;
    case (state_q)
      S_IF: begin
        InsMemRW = 1'b1;
        IRWre    = 1'b1;
      end
      S_ID: begin
        if (cls == C_JMP) begin
          PCWre  = 1'b1;
          PCSrc  = is_jr ? PC_RS : PC_JUMP;
          RegWre = is_jal;
        end
`ifndef ILLEGAL_OP_TRAP_EN
        else if (cls == C_ILLEGAL) begin
          PCWre = 1'b1;
        end
`endif
      end
      S_EXE_BR: begin
        PCWre = 1'b1;
        PCSrc = zero ? PC_BRANCH : PC_NEXT;
      end
      S_MEM: begin
        PCWre     = is_sw;
        DataMemRW = is_sw;
      end
      S_WB_AL: begin
        PCWre     = 1'b1;
        RegWre    = 1'b1;
        WrRegData = 1'b1;
      end
      S_WB_LD: begin
        PCWre     = 1'b1;
        RegWre    = 1'b1;
        WrRegData = 1'b1;
        ALUM2Reg  = 1'b1;
      end
      default: ;
    endcase
    // Asynchronous reset must silence every write strobe immediately.
    if (rst) begin
      PCWre     = 1'b0;
      IRWre     = 1'b0;
      InsMemRW  = 1'b0;
      RegWre    = 1'b0;
      DataMemRW = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IF;
      count_q <= '0;
    end else begin
      if (PCWre) count_q <= count_q + CNT_W'(1);
      case (state_q)
        S_IF: state_q <= S_ID;
        S_ID: begin
          case (cls)
            C_JMP:     state_q <= S_IF;
            C_HALT:    state_q <= S_HALT;
            C_BR:      state_q <= S_EXE_BR;
            C_LS:      state_q <= S_EXE_LS;
`ifdef ILLEGAL_OP_TRAP_EN
            C_ILLEGAL: state_q <= S_HALT;
`else
            C_ILLEGAL: state_q <= S_IF;
`endif
            default:   state_q <= S_EXE_AL;
          endcase
        end
        S_EXE_AL: state_q <= S_WB_AL;
        S_EXE_BR: state_q <= S_IF;
        S_EXE_LS: state_q <= S_MEM;
        S_MEM:    state_q <= is_lw ? S_WB_LD : S_IF;
        S_WB_AL:  state_q <= S_IF;
        S_WB_LD:  state_q <= S_IF;
        S_HALT:   state_q <= S_HALT;
        default:  state_q <= S_IF;
      endcase
    end
  end

`ifdef ILLEGAL_OP_TRAP_EN
  logic illegal_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_q <= 1'b0;
    end else if (state_q == S_ID && cls == C_ILLEGAL) begin
      illegal_q <= 1'b1;
    end
  end

  assign illegal_op = illegal_q;
`else
  assign illegal_op = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: directed scenarios plus a
// randomized instruction stream against a per-instruction timing model.
module tb_multicycle_control_unit;

  localparam int CW = 4;

  localparam logic [3:0] ST_IF = 4'd0, ST_ID = 4'd1, ST_EXE_AL = 4'd2, ST_EXE_BR = 4'd3;
  localparam logic [3:0] ST_EXE_LS = 4'd4, ST_MEM = 4'd5, ST_WB_AL = 4'd6, ST_WB_LD = 4'd7;
  localparam logic [3:0] ST_HALT = 4'd8;

  localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BR = 4;
  localparam int K_J = 5, K_JR = 6, K_JAL = 7, K_HALT = 8, K_ILL = 9;

`ifdef ILLEGAL_OP_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic [5:0] opcode;
  logic zero;
  logic PCWre, IRWre, InsMemRW, RegWre, ALUSrcA, ALUSrcB, ALUM2Reg, WrRegData, DataMemRW;
  logic [1:0] ExtSel, RegOut, PCSrc;
  logic [2:0] ALUOp;
  logic [3:0] state;
  logic [CW-1:0] instr_count;
  logic illegal_op;

  multicycle_control_unit #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
    .PCWre(PCWre), .IRWre(IRWre), .InsMemRW(InsMemRW), .ExtSel(ExtSel),
    .RegOut(RegOut), .RegWre(RegWre), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUM2Reg(ALUM2Reg), .WrRegData(WrRegData), .PCSrc(PCSrc), .ALUOp(ALUOp),
    .DataMemRW(DataMemRW), .state(state), .instr_count(instr_count),
    .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;
  logic [CW-1:0] cnt_model;
  logic [21:0] obs_q [0:24];
  logic [21:0] obs_now;

  assign obs_now = {state, PCWre, IRWre, InsMemRW, RegWre, DataMemRW, PCSrc,
                    RegOut, WrRegData, ALUM2Reg, ALUOp, ALUSrcA, ALUSrcB, ExtSel};

  function automatic int klass(input logic [5:0] op);
    case (op)
      6'b000000, 6'b000001, 6'b010000, 6'b010001, 6'b011000, 6'b100110: return K_R;
      6'b000010, 6'b010010, 6'b100111: return K_I;
      6'b110001: return K_LW;
      6'b110000: return K_SW;
      6'b110100: return K_BR;
      6'b111000: return K_J;
      6'b111001: return K_JR;
      6'b111010: return K_JAL;
      6'b111111: return K_HALT;
      default:   return K_ILL;
    endcase
  endfunction

  function automatic int ilen(input logic [5:0] op);
    case (klass(op))
      K_R, K_I, K_SW: return 4;
      K_LW:           return 5;
      K_BR:           return 3;
      default:        return 2;
    endcase
  endfunction

  // Expected observation vector for cycle idx of instruction op; m selects
  // the fields that are defined in that cycle.
  function automatic logic [21:0] exp_vec(input logic [5:0] op, input logic z,
                                          input int idx, output logic [21:0] m);
    int k, n;
    logic stops, ls, rw;
    logic [3:0] st;
    logic [1:0] ps;
    logic [21:0] e;
    k = klass(op);
    n = ilen(op);
    stops = (k == K_HALT) || (k == K_ILL && TRAP);
    ls = (k == K_LW) || (k == K_SW);
    e = '0;
    m = 22'h3FF800;
    if (idx == 0)      st = ST_IF;
    else if (idx == 1) st = ST_ID;
    else if (stops)    st = ST_HALT;
    else if (idx == 2) st = (k == K_BR) ? ST_EXE_BR : (ls ? ST_EXE_LS : ST_EXE_AL);
    else if (idx == 3) st = ls ? ST_MEM : ST_WB_AL;
    else               st = ST_WB_LD;
    rw = (k == K_JAL && idx == 1) || ((k == K_R || k == K_I) && idx == 3) ||
         (k == K_LW && idx == 4);
    if (idx == 1 && (k == K_J || k == K_JAL)) ps = 2'b11;
    else if (idx == 1 && k == K_JR)           ps = 2'b10;
    else if (k == K_BR && idx == 2 && z)      ps = 2'b01;
    else                                      ps = 2'b00;
    e[21:18] = st;
    e[17] = !stops && (idx == n - 1);
    e[16] = (idx == 0);
    e[15] = (idx == 0);
    e[14] = rw;
    e[13] = (k == K_SW && idx == 3);
    e[12:11] = ps;
    if (rw) begin
      m[10:7] = 4'hF;
      e[10:9] = (k == K_JAL) ? 2'b00 : (k == K_R) ? 2'b10 : 2'b01;
      e[8] = (k != K_JAL);
      e[7] = (k == K_LW);
    end
    if (idx >= 1 && !stops && (k <= K_BR)) begin
      m[6:2] = 5'h1F;
      case (op)
        6'b000001: e[6:2] = {3'b001, 2'b00};
        6'b000010: begin e[6:2] = {3'b000, 2'b01}; m[1:0] = 2'b11; e[1:0] = 2'b10; end
        6'b010000: e[6:2] = {3'b101, 2'b00};
        6'b010001: e[6:2] = {3'b110, 2'b00};
        6'b010010: begin e[6:2] = {3'b101, 2'b01}; m[1:0] = 2'b11; e[1:0] = 2'b01; end
        6'b011000: begin e[6:2] = {3'b100, 2'b10}; m[1:0] = 2'b11; e[1:0] = 2'b00; end
        6'b100110: e[6:2] = {3'b011, 2'b00};
        6'b100111: begin e[6:2] = {3'b010, 2'b01}; m[1:0] = 2'b11; e[1:0] = 2'b10; end
        6'b110000, 6'b110001: begin e[6:2] = {3'b000, 2'b01}; m[1:0] = 2'b11; e[1:0] = 2'b10; end
        6'b110100: begin e[6:2] = {3'b001, 2'b00}; m[1:0] = 2'b11; e[1:0] = 2'b10; end
        default:   e[6:2] = {3'b000, 2'b00};
      endcase
    end
    return e & m;
  endfunction

  // Drives one instruction and records n cycles; returns just after the
  // rising edge that ends the last recorded cycle.
  task automatic run_cycles(input logic [5:0] op, input logic z, input int n);
    opcode = op;
    zero = z;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      obs_q[i] = obs_now;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    opcode = 6'b000000;
    zero = 1'b0;
    repeat (3) begin
      @(negedge clk);
      total++;
      if ({state, PCWre, IRWre, InsMemRW, RegWre, DataMemRW} !== 9'b0000_00000)
        $display("FAIL reset_outputs: got %b, want 000000000",
                 {state, PCWre, IRWre, InsMemRW, RegWre, DataMemRW});
      else passed++;
      total++;
      if (instr_count !== '0) $display("FAIL reset_count: got %0d, want 0", instr_count);
      else passed++;
      total++;
      if (illegal_op !== 1'b0) $display("FAIL reset_illegal: got %b, want 0", illegal_op);
      else passed++;
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    cnt_model = '0;
  endtask

  task automatic test_directed(input string name, input logic [5:0] op, input logic z);
    logic [21:0] e, m;
    run_cycles(op, z, ilen(op));
    for (int i = 0; i < ilen(op); i++) begin
      e = exp_vec(op, z, i, m);
      total++;
      if ((obs_q[i] & m) !== e)
        $display("FAIL %s[%0d]: got %h, want %h", name, i, obs_q[i] & m, e);
      else passed++;
    end
    cnt_model = cnt_model + 1'b1;
    total++;
    if (instr_count !== cnt_model)
      $display("FAIL %s_count: got %0d, want %0d", name, instr_count, cnt_model);
    else passed++;
  endtask

  task automatic test_random;
    logic [5:0] pool [$];
    logic [5:0] op;
    logic z;
    logic [21:0] e, m;
    pool = '{6'b000000, 6'b000001, 6'b000010, 6'b010000, 6'b010001, 6'b010010,
             6'b011000, 6'b100110, 6'b100111, 6'b110000, 6'b110001, 6'b110100,
             6'b111000, 6'b111001, 6'b111010};
    if (!TRAP) pool.push_back(6'b101010);
    for (int t = 0; t < 40; t++) begin
      op = pool[$urandom_range(0, pool.size() - 1)];
      z = 1'($urandom_range(0, 1));
      run_cycles(op, z, ilen(op));
      for (int i = 0; i < ilen(op); i++) begin
        e = exp_vec(op, z, i, m);
        total++;
        if ((obs_q[i] & m) !== e)
          $display("FAIL rand%0d_op%b[%0d]: got %h, want %h", t, op, i, obs_q[i] & m, e);
        else passed++;
      end
      cnt_model = cnt_model + 1'b1;
      total++;
      if (instr_count !== cnt_model)
        $display("FAIL rand%0d_count: got %0d, want %0d", t, instr_count, cnt_model);
      else passed++;
    end
  endtask

  task automatic test_reset_mid;
    run_cycles(6'b110001, 1'b0, 2);
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({state, PCWre, IRWre, InsMemRW, RegWre, DataMemRW} !== 9'b0000_00000)
      $display("FAIL midrst_outputs: got %b, want 000000000",
               {state, PCWre, IRWre, InsMemRW, RegWre, DataMemRW});
    else passed++;
    total++;
    if (instr_count !== '0) $display("FAIL midrst_count: got %0d, want 0", instr_count);
    else passed++;
    repeat (3) begin
      @(negedge clk);
      total++;
      if ({state, RegWre, DataMemRW, PCWre} !== 7'b0000_000)
        $display("FAIL midrst_hold: got %b, want 0000000", {state, RegWre, DataMemRW, PCWre});
      else passed++;
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    cnt_model = '0;
  endtask

  task automatic test_illegal;
    logic [21:0] e, m;
`ifdef ILLEGAL_OP_TRAP_EN
    run_cycles(6'b101010, 1'b0, 6);
    for (int i = 0; i < 6; i++) begin
      e = exp_vec(6'b101010, 1'b0, i, m);
      total++;
      if ((obs_q[i] & m) !== e) $display("FAIL trap[%0d]: got %h, want %h", i, obs_q[i] & m, e);
      else passed++;
    end
    total++;
    if (illegal_op !== 1'b1) $display("FAIL trap_flag: got %b, want 1", illegal_op);
    else passed++;
    total++;
    if (instr_count !== cnt_model)
      $display("FAIL trap_count: got %0d, want %0d", instr_count, cnt_model);
    else passed++;
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (illegal_op !== 1'b0) $display("FAIL trap_clear: got %b, want 0", illegal_op);
    else passed++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cnt_model = '0;
`else
    run_cycles(6'b101010, 1'b0, 2);
    for (int i = 0; i < 2; i++) begin
      e = exp_vec(6'b101010, 1'b0, i, m);
      total++;
      if ((obs_q[i] & m) !== e) $display("FAIL nop[%0d]: got %h, want %h", i, obs_q[i] & m, e);
      else passed++;
    end
    cnt_model = cnt_model + 1'b1;
    total++;
    if (instr_count !== cnt_model)
      $display("FAIL nop_count: got %0d, want %0d", instr_count, cnt_model);
    else passed++;
    total++;
    if (illegal_op !== 1'b0) $display("FAIL nop_flag: got %b, want 0", illegal_op);
    else passed++;
`endif
  endtask

  task automatic test_halt;
    logic [21:0] e, m;
    run_cycles(6'b111111, 1'b0, 22);
    for (int i = 0; i < 22; i++) begin
      e = exp_vec(6'b111111, 1'b0, i, m);
      total++;
      if ((obs_q[i] & m) !== e) $display("FAIL halt[%0d]: got %h, want %h", i, obs_q[i] & m, e);
      else passed++;
    end
    total++;
    if (instr_count !== cnt_model)
      $display("FAIL halt_count: got %0d, want %0d", instr_count, cnt_model);
    else passed++;
  endtask

  initial begin
    test_reset;
    test_directed("add_first", 6'b000000, 1'b0);
    test_directed("beq_taken", 6'b110100, 1'b1);
    test_directed("beq_not_taken", 6'b110100, 1'b0);
    test_directed("lw", 6'b110001, 1'b0);
    test_directed("sw", 6'b110000, 1'b0);
    test_directed("jal", 6'b111010, 1'b0);
    test_directed("sll", 6'b011000, 1'b0);
    test_directed("ori", 6'b010010, 1'b0);
    test_random;
    test_reset_mid;
    test_directed("add_after_rst", 6'b000000, 1'b0);
    test_illegal;
    test_halt;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, want finish before 200000");
    $fatal(1);
  end

endmodule
